mux_pipe_rr: RTL and testbench

- N-channel successor to the single-forward-path pipe multiplexer.
- Each input channel has its own DEPTH-entry FIFO.
- A round-robin arbiter drains the non-empty FIFOs onto one ENA/RDY output pipe, one word per cycle.
- Used at the top level to merge the indication path, printf/debug streams and further sources onto one outbound 128-bit message pipe.
- No input bypass path: every word is buffered, giving fair, deterministic ordering.

---
 rtl/mux_pipe_rr.sv | 118 +++++++++++
 tb/tb_mux_pipe_rr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_rr.sv
// mux_pipe_rr: N input channels, each with its own DEPTH-entry FIFO, merged onto one ENA/RDY pipe.
// A round-robin arbiter drains the non-empty FIFOs one word per cycle; no input-to-output bypass.
module mux_pipe_rr #(
  parameter int WIDTH = 128,
  parameter int N     = 2,
  parameter int DEPTH = 2,
  parameter int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [N-1:0]                      in_enq__ENA,
  input  logic [N*WIDTH-1:0]                in_enq_v,
  output logic [N-1:0]                      in_enq__RDY,
  output logic                              out_enq__ENA,
  output logic [WIDTH-1:0]                  out_enq_v,
  output logic [CW-1:0]                     out_enq_chan,
  input  logic                              out_enq__RDY,
  output logic [N*($clog2(DEPTH)+1)-1:0]    occupancy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [CW:0]     NCH  = (CW+1)'(N);

  logic [N-1:0]       w_req;
  logic [N-1:0]       w_enq;
  logic [N-1:0]       w_deq;
  logic [WIDTH-1:0]   w_head [N];
  logic [CW-1:0]      r_ptr;
  logic [CW-1:0]      w_grant;
  logic [CW:0]        w_idx;
  logic [CW:0]        w_next;
  logic               w_found;
  logic               w_any;
  logic               w_xfer;

  // Per-channel circular buffer; RDY comes from the registered count only,
  // so there is no combinational path from the downstream ready.
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CNTW-1:0]  r_count;

    assign w_req[i]       = (r_count != '0);
    assign in_enq__RDY[i] = (r_count != FULL);
    assign w_enq[i]       = in_enq__ENA[i] & in_enq__RDY[i];
    assign w_deq[i]       = w_xfer & (w_grant == CW'(i));
    assign w_head[i]      = r_mem[r_rdPtr];
    assign occupancy[i*CNTW +: CNTW] = r_count;

    always_ff @(posedge CLK) begin
      if (w_enq[i]) begin
        r_mem[r_wrPtr] <= in_enq_v[i*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge CLK) begin
      if (!nRST) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_enq[i]) begin
          r_wrPtr <= r_wrPtr + AW'(1);
        end
        if (w_deq[i]) begin
          r_rdPtr <= r_rdPtr + AW'(1);
        end
        case ({w_enq[i], w_deq[i]})
          2'b10:   r_count <= r_count + CNTW'(1);
          2'b01:   r_count <= r_count - CNTW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Scan channels starting at the round-robin pointer, wrapping past N-1.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_grant = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_ptr} + (CW+1)'(k);
      if (w_idx >= NCH) begin
        w_idx = w_idx - NCH;
      end
      if (!w_found && w_req[w_idx[CW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[CW-1:0];
      end
    end
  end

  always_comb begin
    w_next = {1'b0, w_grant} + (CW+1)'(1);
    if (w_next >= NCH) begin
      w_next = '0;
    end
  end

  assign w_any        = |w_req;
  assign w_xfer       = nRST & w_any & out_enq__RDY;
  assign out_enq__ENA = w_xfer;
  assign out_enq_v    = w_any ? w_head[w_grant] : '0;
  assign out_enq_chan = w_grant;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_next[CW-1:0];
    end
  end

endmodule

// File: tb/tb_mux_pipe_rr.sv
// Scoreboard bench for mux_pipe_rr with N=3, DEPTH=2: stimulus pushes expected words,
// a negedge monitor pops and compares every output transfer.
module tb_mux_pipe_rr;

  localparam int WIDTH = 128;
  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int CW    = 2;
  localparam int OW    = 2;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [N-1:0]         inEna;
  logic [N*WIDTH-1:0]   inData;
  logic [N-1:0]         inRdy;
  logic                 outEna;
  logic [WIDTH-1:0]     outData;
  logic [CW-1:0]        outChan;
  logic                 outRdy;
  logic [N*OW-1:0]      occupancy;

  typedef struct packed {
    logic [CW-1:0]    chan;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   drainCycles;

  mux_pipe_rr #(.WIDTH(WIDTH), .N(N), .DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (inEna),
    .in_enq_v     (inData),
    .in_enq__RDY  (inRdy),
    .out_enq__ENA (outEna),
    .out_enq_v    (outData),
    .out_enq_chan (outChan),
    .out_enq__RDY (outRdy),
    .occupancy    (occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [WIDTH+7:0] actual,
                             input logic [WIDTH+7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  task automatic expectOut(input int ch, input logic [WIDTH-1:0] data);
    exp_t e;
    e.chan = CW'(ch);
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int ch, input logic [WIDTH-1:0] data);
    checkOutput("enqWhileFull", WIDTH'(inRdy[ch]), WIDTH'(1));
    inEna[ch] = 1'b1;
    inData[ch*WIDTH +: WIDTH] = data;
    tick();
    inEna = '0;
  endtask

  task automatic enqMulti(input logic [N-1:0] mask, input logic [WIDTH-1:0] d0,
                          input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
    checkOutput("enqWhileFull", WIDTH'(inRdy & mask), WIDTH'(mask));
    inEna = mask;
    inData[0*WIDTH +: WIDTH] = d0;
    inData[1*WIDTH +: WIDTH] = d1;
    inData[2*WIDTH +: WIDTH] = d2;
    tick();
    inEna = '0;
  endtask

  task automatic resetDut();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  // Wait for the scoreboard to empty, then realign to just after a rising edge.
  task automatic waitDrain(input int maxCycles, output int cycles);
    cycles = 0;
    while (expQ.size() != 0 && cycles < maxCycles) begin
      settle();
      cycles++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drainTimeout: %0d words outstanding after %0d cycles", expQ.size(), cycles);
      expQ.delete();
    end
    tick();
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!nRST) begin
      checkOutput("enaInReset", WIDTH'(outEna), '0);
    end else if (outEna) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedOut: got chan %0d data %0h, expected no transfer", outChan, outData);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("outChan", WIDTH'(outChan), WIDTH'(e.chan));
        checkOutput("outData", outData, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nRST   = 1'b0;
    inEna  = '0;
    inData = '0;
    outRdy = 1'b0;

    // 1: reset values, then single-word latency
    tick();
    tick();
    nRST = 1'b1;
    settle();
    checkOutput("rstInRdy", WIDTH'(inRdy), WIDTH'(3'b111));
    checkOutput("rstOutEna", WIDTH'(outEna), '0);
    checkOutput("rstOcc", WIDTH'(occupancy), '0);
    checkOutput("rstOutData", outData, '0);
    checkOutput("rstOutChan", WIDTH'(outChan), '0);
    tick();
    outRdy = 1'b1;
    expectOut(1, 'hA);
    applyStimulus(1, 'hA);
    waitDrain(4, drainCycles);
    settle();
    checkOutput("singleDone", WIDTH'(outEna), '0);

    // 2: round robin over three preloaded channels
    tick();
    outRdy = 1'b0;
    resetDut();
    enqMulti(3'b111, 'h10, 'h20, 'h30);
    enqMulti(3'b111, 'h11, 'h21, 'h31);
    settle();
    checkOutput("rrOccFull", WIDTH'(occupancy), WIDTH'(6'b10_10_10));
    checkOutput("rrInRdy", WIDTH'(inRdy), '0);
    tick();
    expectOut(0, 'h10); expectOut(1, 'h20); expectOut(2, 'h30);
    expectOut(0, 'h11); expectOut(1, 'h21); expectOut(2, 'h31);
    outRdy = 1'b1;
    waitDrain(20, drainCycles);
    checkOutput("rrCycles", WIDTH'(drainCycles), WIDTH'(6));
    settle();
    checkOutput("rrIdleEna", WIDTH'(outEna), '0);
    checkOutput("rrIdleOcc", WIDTH'(occupancy), '0);

    // 3: full channel under backpressure, plus an ignored enqueue while full
    tick();
    outRdy = 1'b0;
    applyStimulus(0, 'h1);
    applyStimulus(0, 'h2);
    settle();
    checkOutput("fullInRdy0", WIDTH'(inRdy[0]), '0);
    checkOutput("fullOcc0", WIDTH'(occupancy[1:0]), WIDTH'(2));
    for (int c = 0; c < 5; c++) begin
      checkOutput("stallData", outData, 'h1);
      checkOutput("stallChan", WIDTH'(outChan), '0);
      checkOutput("stallEna", WIDTH'(outEna), '0);
      settle();
    end
    tick();
    inEna[0] = 1'b1;
    inData[0 +: WIDTH] = 'h3;
    tick();
    inEna = '0;
    settle();
    checkOutput("violOcc0", WIDTH'(occupancy[1:0]), WIDTH'(2));
    tick();
    expectOut(0, 'h1);
    expectOut(0, 'h2);
    outRdy = 1'b1;
    settle();
    checkOutput("rdyStillLow", WIDTH'(inRdy[0]), '0);
    settle();
    checkOutput("rdyReturns", WIDTH'(inRdy[0]), WIDTH'(1));
    waitDrain(6, drainCycles);

    // 4: enqueue and dequeue on the same edge
    expectOut(2, 'h5);
    expectOut(2, 'h6);
    applyStimulus(2, 'h5);
    applyStimulus(2, 'h6);
    settle();
    checkOutput("simulOcc2", WIDTH'(occupancy[5:4]), WIDTH'(1));
    settle();
    checkOutput("simulOcc2Empty", WIDTH'(occupancy[5:4]), '0);
    waitDrain(4, drainCycles);

    // 5: pointer at 1 with only channels 2 and 0 pending
    resetDut();
    outRdy = 1'b1;
    expectOut(0, 'h3F);
    applyStimulus(0, 'h3F);
    waitDrain(4, drainCycles);
    outRdy = 1'b0;
    enqMulti(3'b101, 'h40, 'h0, 'h42);
    settle();
    checkOutput("skipChan", WIDTH'(outChan), WIDTH'(2));
    checkOutput("skipData", outData, 'h42);
    tick();
    expectOut(2, 'h42);
    expectOut(0, 'h40);
    outRdy = 1'b1;
    waitDrain(6, drainCycles);
    outRdy = 1'b0;
    enqMulti(3'b111, 'h50, 'h51, 'h52);
    settle();
    checkOutput("ptrAfterWrap", WIDTH'(outChan), WIDTH'(1));
    tick();
    expectOut(1, 'h51);
    expectOut(2, 'h52);
    expectOut(0, 'h50);
    outRdy = 1'b1;
    waitDrain(8, drainCycles);

    // 6: reset with every FIFO full discards everything
    outRdy = 1'b0;
    enqMulti(3'b111, 'h60, 'h61, 'h62);
    enqMulti(3'b111, 'h63, 'h64, 'h65);
    settle();
    checkOutput("preRstOcc", WIDTH'(occupancy), WIDTH'(6'b10_10_10));
    tick();
    nRST   = 1'b0;
    outRdy = 1'b1;
    tick();
    nRST = 1'b1;
    settle();
    checkOutput("midRstOcc", WIDTH'(occupancy), '0);
    checkOutput("midRstEna", WIDTH'(outEna), '0);
    checkOutput("midRstData", outData, '0);
    checkOutput("midRstInRdy", WIDTH'(inRdy), WIDTH'(3'b111));
    outRdy = 1'b0;
    tick();
    enqMulti(3'b111, 'h70, 'h71, 'h72);
    settle();
    checkOutput("midRstPtr", WIDTH'(outChan), '0);
    tick();
    expectOut(0, 'h70);
    expectOut(1, 'h71);
    expectOut(2, 'h72);
    outRdy = 1'b1;
    waitDrain(8, drainCycles);
    repeat (4) settle();
    checkOutput("finalOcc", WIDTH'(occupancy), '0);
    checkOutput("finalQueue", WIDTH'(expQ.size()), '0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
